// File: rtl/trace_check_arbiter.sv
// Round-robin arbiter sharing one cpu_checker between two trace-line sources, one whole record at a time.
// Optional result counters (cnt_pc/cnt_addr/cnt_err) are built when TRACE_ARB_STATS_EN is defined.
module trace_check_arbiter #(
    parameter int          MAX_LEN  = 64,
    parameter logic [7:0]  GAP_CHAR = 8'h0A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    output logic       res0_valid,
    output logic       res1_valid,
    output logic [1:0] res_type,
    output logic [7:0] chk_char,
    input  logic [1:0] chk_format_type
`ifdef TRACE_ARB_STATS_EN
    ,
    output logic [15:0] cnt_pc,
    output logic [15:0] cnt_addr,
    output logic [15:0] cnt_err
`endif
);

    localparam int             LW        = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0]  MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [7:0]     HASH      = 8'h23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEP,
        S_STREAM,
        S_DRAIN,
        S_WAIT,
        S_ABORT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          ptr_q, ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic          res0Valid_q, res0Valid_d;
    logic          res1Valid_q, res1Valid_d;
    logic [1:0]    resType_q, resType_d;

    logic          ownerValid;
    logic [7:0]    ownerChar;
    logic          ownerReady;
    logic [LW-1:0] lenInc;

    assign ownerValid = owner_q ? req1_valid : req0_valid;
    assign ownerChar  = owner_q ? req1_char  : req0_char;
    assign ownerReady = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign lenInc     = len_q + LW'(1);

    assign req0_ready = ownerReady && !owner_q;
    assign req1_ready = ownerReady && owner_q;
    assign chk_char   = (state_q == S_STREAM && ownerValid) ? ownerChar : GAP_CHAR;
    assign res0_valid = res0Valid_q;
    assign res1_valid = res1Valid_q;
    assign res_type   = resType_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            len_q       <= '0;
            res0Valid_q <= 1'b0;
            res1Valid_q <= 1'b0;
            resType_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            res0Valid_q <= res0Valid_d;
            res1Valid_q <= res1Valid_d;
            resType_q   <= resType_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        res0Valid_d = 1'b0;
        res1Valid_d = 1'b0;
        resType_d   = resType_q;

        case (state_q)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    owner_d = ptr_q;
                    state_d = S_SEP;
                end else if (req0_valid) begin
                    owner_d = 1'b0;
                    state_d = S_SEP;
                end else if (req1_valid) begin
                    owner_d = 1'b1;
                    state_d = S_SEP;
                end
            end
            S_SEP: begin
                len_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (ownerValid) begin
                    len_d = lenInc;
                    if (ownerChar == HASH) begin
                        state_d = S_WAIT;
                    end else if (lenInc == MAX_LEN_L) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (ownerValid && ownerChar == HASH) begin
                    state_d = S_ABORT;
                end
            end
            // The checker's verdict for '#' appears exactly one cycle after it was forwarded.
            S_WAIT: begin
                resType_d   = chk_format_type;
                res0Valid_d = !owner_q;
                res1Valid_d = owner_q;
                state_d     = S_DONE;
            end
            S_ABORT: begin
                resType_d   = 2'b00;
                res0Valid_d = !owner_q;
                res1Valid_d = owner_q;
                state_d     = S_DONE;
            end
            S_DONE: begin
                ptr_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef TRACE_ARB_STATS_EN
    logic [15:0] cntPc_q, cntAddr_q, cntErr_q;

    // Aborted records carry res_type 00, so they land in the error bucket naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cntPc_q   <= '0;
            cntAddr_q <= '0;
            cntErr_q  <= '0;
        end else if (state_q == S_DONE) begin
            if (resType_q == 2'b01) begin
                if (cntPc_q != 16'hFFFF) cntPc_q <= cntPc_q + 16'd1;
            end else if (resType_q == 2'b10) begin
                if (cntAddr_q != 16'hFFFF) cntAddr_q <= cntAddr_q + 16'd1;
            end else begin
                if (cntErr_q != 16'hFFFF) cntErr_q <= cntErr_q + 16'd1;
            end
        end
    end

    assign cnt_pc   = cntPc_q;
    assign cnt_addr = cntAddr_q;
    assign cnt_err  = cntErr_q;
`endif

endmodule

// File: tb/tb_trace_check_arbiter.sv
// Self-checking bench for trace_check_arbiter: vector table, corner-case sequences and randomized records
// scored against a record-level model; a small behavioural checker stands in for cpu_checker.
module tb_trace_check_arbiter;

    localparam int         MAX_LEN = 64;
    localparam logic [7:0] GAP     = 8'h0A;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_char = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_char = 8'h00;
    logic       req1_ready;
    logic       res0_valid;
    logic       res1_valid;
    logic [1:0] res_type;
    logic [7:0] chk_char;
    logic [1:0] chk_format_type = 2'b00;
`ifdef TRACE_ARB_STATS_EN
    logic [15:0] cnt_pc, cnt_addr, cnt_err;
`endif

    trace_check_arbiter #(.MAX_LEN(MAX_LEN), .GAP_CHAR(GAP)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_char       (req0_char),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_char       (req1_char),
        .req1_ready      (req1_ready),
        .res0_valid      (res0_valid),
        .res1_valid      (res1_valid),
        .res_type        (res_type),
        .chk_char        (chk_char),
        .chk_format_type (chk_format_type)
`ifdef TRACE_ARB_STATS_EN
        ,
        .cnt_pc          (cnt_pc),
        .cnt_addr        (cnt_addr),
        .cnt_err         (cnt_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A well-formed line starts with '^', has '@', and is a pc line ('$') or an addr line ('*').
    function automatic logic [1:0] classify(input string s);
        bit hasAt = 0, hasDollar = 0, hasStar = 0;
        if (s.len() == 0) return 2'b00;
        if (s[0] != 8'h5E) return 2'b00;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h40) hasAt = 1;
            if (s[i] == 8'h24) hasDollar = 1;
            if (s[i] == 8'h2A) hasStar = 1;
        end
        if (!hasAt) return 2'b00;
        if (hasDollar) return 2'b01;
        if (hasStar) return 2'b10;
        return 2'b00;
    endfunction

    // Stand-in checker: any gap restarts it, verdict appears the cycle after '#'.
    string ckBuf = "";
    always @(posedge clk) begin
        if (chk_char == GAP) begin
            ckBuf = "";
            chk_format_type <= 2'b00;
        end else if (chk_char == 8'h23) begin
            chk_format_type <= classify(ckBuf);
            ckBuf = "";
        end else begin
            ckBuf = $sformatf("%s%c", ckBuf, chk_char);
            chk_format_type <= 2'b00;
        end
    end

    typedef struct {
        logic [1:0] t;
        int         due;
    } exp_t;

    exp_t  expQ0[$];
    exp_t  expQ1[$];
    int    mCnt[2];
    string mStr[2];
    bit    mBub[2];
    int    resCount[2];
    logic [1:0] resLast[2];
    int    resOrder[$];
    logic [1:0] lastResType = 2'b00;

    task automatic track(input int src, input bit acc, input bit rdy, input bit vld, input logic [7:0] ch);
        exp_t e;
        if (rdy && !vld && mCnt[src] > 0) mBub[src] = 1;
        if (acc) begin
            mCnt[src]++;
            if (ch == 8'h23) begin
                e.t   = (mCnt[src] > MAX_LEN || mBub[src]) ? 2'b00 : classify(mStr[src]);
                e.due = cyc + 2;
                if (src == 0) expQ0.push_back(e); else expQ1.push_back(e);
                mCnt[src] = 0;
                mStr[src] = "";
                mBub[src] = 0;
            end else begin
                mStr[src] = $sformatf("%s%c", mStr[src], ch);
            end
        end
    endtask

    task automatic handleResult(input int src);
        exp_t e;
        if ((src == 0 && expQ0.size() == 0) || (src == 1 && expQ1.size() == 0)) begin
            checkOutput($sformatf("unexpectedRes%0d", src), 1, 0);
        end else begin
            e = (src == 0) ? expQ0.pop_front() : expQ1.pop_front();
            checkOutput($sformatf("resType%0d", src), res_type, e.t);
            checkOutput($sformatf("resLatency%0d", src), cyc, e.due);
        end
        lastResType   = res_type;
        resLast[src]  = res_type;
        resCount[src] = resCount[src] + 1;
        resOrder.push_back(src);
    endtask

    always @(negedge clk) begin
        logic [7:0] expChk;
        bit acc0, acc1;
        if (reset) begin
            expQ0.delete();
            expQ1.delete();
            for (int i = 0; i < 2; i++) begin
                mCnt[i] = 0;
                mStr[i] = "";
                mBub[i] = 0;
            end
            lastResType = 2'b00;
        end else begin
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            checkOutput("readyExclusive", req0_ready && req1_ready, 0);
            checkOutput("resExclusive", res0_valid && res1_valid, 0);
            expChk = GAP;
            if (acc0 && mCnt[0] < MAX_LEN) expChk = req0_char;
            if (acc1 && mCnt[1] < MAX_LEN) expChk = req1_char;
            checkOutput("chkChar", chk_char, expChk);
            track(0, acc0, req0_ready, req0_valid, req0_char);
            track(1, acc1, req1_ready, req1_valid, req1_char);
            if (res0_valid) handleResult(0);
            else if (res1_valid) handleResult(1);
            else checkOutput("resTypeHold", res_type, lastResType);
        end
    end

    task automatic setReq(input int src, input bit v, input logic [7:0] c);
        if (src == 0) begin
            req0_valid = v;
            req0_char  = c;
        end else begin
            req1_valid = v;
            req1_char  = c;
        end
    endtask

    function automatic bit readyOf(input int src);
        return (src == 0) ? req0_ready : req1_ready;
    endfunction

    // Called just after a posedge; returns just after the posedge that took the last character.
    task automatic sendRecord(input int src, input string line, input int bubbleAt);
        int t;
        for (int i = 0; i < line.len(); i++) begin
            if (i == bubbleAt && i > 0) begin
                setReq(src, 0, 8'h00);
                @(posedge clk);
                #1;
            end
            setReq(src, 1, line[i]);
            t = 0;
            forever begin
                @(negedge clk);
                if (readyOf(src)) break;
                t++;
                if (t > 600) begin
                    checkOutput($sformatf("grantTimeout%0d", src), 0, 1);
                    setReq(src, 0, 8'h00);
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        setReq(src, 0, 8'h00);
    endtask

    task automatic expectResult(input int src, input int snap, input logic [1:0] exp, input string name);
        int t = 0;
        while (resCount[src] == snap && t < 200) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (resCount[src] == snap) checkOutput({name, "Timeout"}, 0, 1);
        else checkOutput(name, resLast[src], exp);
    endtask

    typedef struct {
        int         src;
        string      line;
        int         bubbleAt;
        logic [1:0] expType;
    } vec_t;

    task automatic applyStimulus(input vec_t v, input string name);
        int snap = resCount[v.src];
        sendRecord(v.src, v.line, v.bubbleAt);
        expectResult(v.src, snap, v.expType, name);
    endtask

    function automatic string makeFill(input int n);
        string s = "^@$";
        while (s.len() < n - 1) s = {s, "x"};
        return {s, "#"};
    endfunction

    function automatic string hex8();
        string s = "";
        for (int i = 0; i < 8; i++) s = $sformatf("%s%h", s, 4'($urandom_range(0, 15)));
        return s;
    endfunction

    function automatic string genLine();
        string s;
        case ($urandom_range(0, 3))
            0: s = $sformatf("^%0d@%s: $%0d <= %s#", $urandom_range(1, 99), hex8(), $urandom_range(1, 31), hex8());
            1: s = $sformatf("^%0d@%s: *%s<=%s#", $urandom_range(1, 99), hex8(), hex8(), hex8());
            2: begin
                s = "";
                for (int i = 0; i < $urandom_range(3, 20); i++) s = $sformatf("%s%c", s, $urandom_range(97, 122));
                s = {s, "#"};
            end
            default: s = makeFill($urandom_range(60, 70));
        endcase
        return s;
    endfunction

    task automatic randomRecord(input int src);
        string line = genLine();
        int bub = ($urandom_range(0, 3) == 0) ? $urandom_range(1, line.len() - 1) : -1;
        sendRecord(src, line, bub);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        setReq(0, 0, 8'h00);
        setReq(1, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    localparam string PC_LINE   = "^12@0000300c: $8 <= 0000000a#";
    localparam string ADDR_LINE = "^5@00003000: *00000010<=deadbeef#";

    vec_t vecs[8];

    initial begin
        int s0, s1;
        bit sawRes;

        vecs[0] = '{0, PC_LINE, -1, 2'b01};
        vecs[1] = '{1, ADDR_LINE, -1, 2'b10};
        vecs[2] = '{1, PC_LINE, 8, 2'b00};
        vecs[3] = '{0, makeFill(70), -1, 2'b00};
        vecs[4] = '{0, makeFill(64), -1, 2'b01};
        vecs[5] = '{1, makeFill(65), -1, 2'b00};
        vecs[6] = '{0, "hello#", -1, 2'b00};
        vecs[7] = '{1, makeFill(63), -1, 2'b01};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rstReady0", req0_ready, 0);
        checkOutput("rstReady1", req1_ready, 0);
        checkOutput("rstChkChar", chk_char, GAP);
        checkOutput("rstRes0", res0_valid, 0);
        checkOutput("rstRes1", res1_valid, 0);
        checkOutput("rstResType", res_type, 0);

        $display("[TB] both sources valid from reset");
        s0 = resCount[0];
        s1 = resCount[1];
        resOrder.delete();
        fork
            sendRecord(0, ADDR_LINE, -1);
            sendRecord(1, PC_LINE, -1);
        join
        expectResult(0, s0, 2'b10, "bothSrc0");
        expectResult(1, s1, 2'b01, "bothSrc1");
        checkOutput("bothOrderFirst", (resOrder.size() >= 1) ? resOrder[0] : 9, 0);
        checkOutput("bothOrderSecond", (resOrder.size() >= 2) ? resOrder[1] : 9, 1);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        $display("[TB] pointer follows last owner");
        applyStimulus(vecs[0], "ptrPrep");
        s0 = resCount[0];
        s1 = resCount[1];
        resOrder.delete();
        fork
            sendRecord(0, PC_LINE, -1);
            sendRecord(1, ADDR_LINE, -1);
        join
        expectResult(0, s0, 2'b01, "ptrSrc0");
        expectResult(1, s1, 2'b10, "ptrSrc1");
        checkOutput("ptrOrderFirst", (resOrder.size() >= 1) ? resOrder[0] : 9, 1);

        $display("[TB] reset during stream");
        @(posedge clk);
        #1;
        setReq(0, 1, 8'h5E);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstReady0", req0_ready, 0);
        checkOutput("midRstReady1", req1_ready, 0);
        checkOutput("midRstChkChar", chk_char, GAP);
        checkOutput("midRstResType", res_type, 0);
        reset = 1'b0;
        setReq(0, 0, 8'h00);
        sawRes = 0;
        for (int i = 0; i < 6; i++) begin
            if (res0_valid || res1_valid) sawRes = 1;
            @(posedge clk);
            #1;
        end
        checkOutput("midRstNoPulse", sawRes, 0);
        applyStimulus(vecs[1], "postRst");

        $display("[TB] randomized records");
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: randomRecord(0);
                1: randomRecord(1);
                default: fork
                    randomRecord(0);
                    randomRecord(1);
                join
            endcase
        end
        repeat (20) @(posedge clk);
        #1;
        checkOutput("pendingResults", expQ0.size() + expQ1.size(), 0);

`ifdef TRACE_ARB_STATS_EN
        $display("[TB] statistics counters");
        doReset();
        checkOutput("cntPcRst", cnt_pc, 0);
        applyStimulus(vecs[0], "statPc");
        applyStimulus('{0, ADDR_LINE, -1, 2'b10}, "statAddr");
        applyStimulus(vecs[3], "statAbort");
        @(posedge clk);
        #1;
        checkOutput("cntPc", cnt_pc, 1);
        checkOutput("cntAddr", cnt_addr, 1);
        checkOutput("cntErr", cnt_err, 1);
`else
        doReset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
